// File: rtl/nios2_debug_slave_sysclk_fifo.sv
// System-clock side of the JTAG debug slave: synchronises update-DR/IR strobes and queues DR captures.
// Capture lands SYNC_STAGES+1 clks after vs_udr rises; consumer backpressure via cmd_ready, full FIFO drops and flags overflow.
module nios2_debug_slave_sysclk_fifo #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 35,
    localparam int FILL_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [DR_W-1:0]   sr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [DR_W-1:0]   cmd_data,
    output logic              cmd_action,
    output logic              uir_pulse,
    output logic [FILL_W-1:0] fill,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_MAX  = ARM_W'(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_edge;
    logic                   r_uir_edge;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   r_uir_pulse;
    logic                   r_ovf;
    logic [FILL_W-1:0]      r_fill;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [DR_W-1:0]        r_mem_data [DEPTH];
    logic [IR_W-1:0]        r_mem_ir   [DEPTH];

    logic w_armed;
    logic w_udr_rise;
    logic w_uir_rise;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Levels present at reset release must not look like fresh strobes, so
    // edge detection waits until the synchronisers have flushed.
    assign w_armed    = (r_arm_cnt == ARM_MAX);
    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_edge & w_armed;
    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_edge & w_armed;

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FULL_CNT);
    assign w_pop   = ~w_empty & cmd_ready;
    assign w_push  = w_udr_rise & (~w_full | w_pop);
    assign w_drop  = w_udr_rise & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_udr_sync  <= '0;
            r_uir_sync  <= '0;
            r_udr_edge  <= 1'b0;
            r_uir_edge  <= 1'b0;
            r_arm_cnt   <= '0;
            r_uir_pulse <= 1'b0;
        end else begin
            r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_edge  <= r_udr_sync[SYNC_STAGES-1];
            r_uir_edge  <= r_uir_sync[SYNC_STAGES-1];
            r_uir_pulse <= w_uir_rise;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
            // A drop coinciding with a clear must stay visible.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset: head outputs are gated by cmd_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= sr;
            r_mem_ir[r_wr_ptr]   <= ir_in;
        end
    end

    assign cmd_valid  = ~w_empty;
    assign cmd_data   = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign cmd_ir     = w_empty ? '0 : r_mem_ir[r_rd_ptr];
    assign cmd_action = cmd_data[ACT_BIT];
    assign uir_pulse  = r_uir_pulse;
    assign fill       = r_fill;
    assign overflow   = r_ovf;

endmodule
